// File: rtl/processor_status_register_if.sv
// processor_status_register_if
//   Bundles the flag/stack/push signals between the control sequencer
//   (master) and the 6502 P register (slave).
//   master drives: flags_in, flags_ena, flag_op, pull_valid, pull_data,
//                  int_set_i, push_brk
//   slave drives:  p_out, push_data, irq_mask
interface processor_status_register_if;
    logic [7:0] flags_in;
    logic [7:0] flags_ena;
    logic [2:0] flag_op;
    logic       pull_valid;
    logic [7:0] pull_data;
    logic       int_set_i;
    logic       push_brk;
    logic [7:0] p_out;
    logic [7:0] push_data;
    logic       irq_mask;

    modport master (
        output flags_in, flags_ena, flag_op, pull_valid, pull_data,
               int_set_i, push_brk,
        input  p_out, push_data, irq_mask
    );

    modport slave (
        input  flags_in, flags_ena, flag_op, pull_valid, pull_data,
               int_set_i, push_brk,
        output p_out, push_data, irq_mask
    );
endinterface

// File: rtl/processor_status_register.sv
// processor_status_register
//   6502 P register. Applies masked ALU flag writes, the SEC/CLC/SEI/CLI/
//   SED/CLD/CLV ops, PLP/RTI loads, interrupt-entry I set, and formats P for
//   stack pushes. Also produces the delayed I mask used by IRQ recognition.
//   Ports:
//     clk    in  system clock, rising edge
//     reset  in  asynchronous active-high reset
//     bus    slave side of processor_status_register_if
//            (flags_in/flags_ena/flag_op/pull_valid/pull_data/int_set_i/
//             push_brk in; p_out/push_data/irq_mask out)
module processor_status_register #(
    parameter logic [7:0]  RESET_P        = 8'h24,
    parameter int unsigned IRQ_MASK_DELAY = 1
) (
    input logic                           clk,
    input logic                           reset,
    processor_status_register_if.slave    bus
);
    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_CLC  = 3'd1,
        OP_SEC  = 3'd2,
        OP_CLI  = 3'd3,
        OP_SEI  = 3'd4,
        OP_CLD  = 3'd5,
        OP_SED  = 3'd6,
        OP_CLV  = 3'd7
    } flag_op_e;

    // Bit 5 always reads 1, bit 4 (B) is never stored.
    localparam logic [7:0] RESET_FORCED = {RESET_P[7:6], 2'b10, RESET_P[3:0]};
    // Keep at least one stage so the vector is legal when the delay is 0.
    localparam int unsigned DL = (IRQ_MASK_DELAY == 0) ? 1 : IRQ_MASK_DELAY;

    flag_op_e        op;
    logic [7:0]      p;
    logic [7:0]      p_next;
    logic            set_i;
    logic [DL-1:0]   dl;
    logic            irq_r;
    logic            irq_tap;

    assign op = flag_op_e'(bus.flag_op);

    always_comb begin
        p_next = p;
        set_i  = 1'b0;
        if (bus.pull_valid) begin
            p_next = bus.pull_data;
        end else begin
            p_next = (p & ~bus.flags_ena) | (bus.flags_in & bus.flags_ena);
            // Explicit flag ops override the ALU write on their target bit.
            unique case (op)
                OP_NONE: ;
                OP_CLC:  p_next[0] = 1'b0;
                OP_SEC:  p_next[0] = 1'b1;
                OP_CLI:  p_next[2] = 1'b0;
                OP_SEI:  p_next[2] = 1'b1;
                OP_CLD:  p_next[3] = 1'b0;
                OP_SED:  p_next[3] = 1'b1;
                OP_CLV:  p_next[6] = 1'b0;
            endcase
            // Interrupt entry wins over a same-cycle CLI.
            set_i = bus.int_set_i;
            if (set_i) p_next[2] = 1'b1;
        end
        p_next[5] = 1'b1;
        p_next[4] = 1'b0;
    end

    // With no delay the mask simply follows P[2] on the same edge.
    assign irq_tap = (IRQ_MASK_DELAY == 0) ? p_next[2] : dl[DL-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p     <= RESET_FORCED;
            dl    <= {DL{RESET_P[2]}};
            irq_r <= RESET_P[2];
        end else begin
            p <= p_next;
            if (set_i) begin
                // Interrupt entry masks immediately; flushing the line with 1s
                // stops older cleared values from re-emerging afterwards.
                dl    <= '1;
                irq_r <= 1'b1;
            end else begin
                dl[0] <= p_next[2];
                for (int unsigned k = 1; k < DL; k++) begin
                    dl[k] <= dl[k-1];
                end
                irq_r <= irq_tap;
            end
        end
    end

    assign bus.p_out     = p;
    assign bus.push_data = {p[7:6], 1'b1, bus.push_brk, p[3:0]};
    assign bus.irq_mask  = irq_r;
endmodule

// File: tb/tb_processor_status_register.sv
module tb_processor_status_register;
    localparam logic [7:0]  RP = 8'h24;
    localparam int unsigned D  = 2;

    typedef struct {
        logic [7:0] p;
        logic       irq;
        logic [7:0] push;
    } exp_t;

    logic clk;
    logic reset;
    processor_status_register_if bus();

    processor_status_register #(.RESET_P(RP), .IRQ_MASK_DELAY(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    // Reference model: P as a byte, I-mask history as a FIFO of D values.
    logic [7:0] mp;
    logic       mirq;
    logic       hist[$];

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mp   = RP;
        mirq = RP[2];
        hist.delete();
        for (int i = 0; i < int'(D); i++) hist.push_back(RP[2]);
    endtask

    // Apply one cycle of stimulus at the falling edge and record what the
    // next rising edge must produce.
    task automatic drive(input logic [7:0] fin, input logic [7:0] ena, input logic [2:0] op,
                         input logic pull, input logic [7:0] pd, input logic is, input logic brk);
        logic is_eff;
        exp_t e;
        @(negedge clk);
        reset          = 1'b0;
        bus.flags_in   = fin;
        bus.flags_ena  = ena;
        bus.flag_op    = op;
        bus.pull_valid = pull;
        bus.pull_data  = pd;
        bus.int_set_i  = is;
        bus.push_brk   = brk;
        is_eff = is & ~pull;
        if (pull) begin
            mp = pd;
        end else begin
            mp = (mp & ~ena) | (fin & ena);
            case (op)
                3'd1: mp[0] = 1'b0;
                3'd2: mp[0] = 1'b1;
                3'd3: mp[2] = 1'b0;
                3'd4: mp[2] = 1'b1;
                3'd5: mp[3] = 1'b0;
                3'd6: mp[3] = 1'b1;
                3'd7: mp[6] = 1'b0;
                default: ;
            endcase
            if (is_eff) mp[2] = 1'b1;
        end
        mp = (mp | 8'h20) & 8'hEF;
        if (D == 0) begin
            mirq = mp[2];
        end else begin
            hist.push_back(mp[2]);
            mirq = hist.pop_front();
            if (is_eff) begin
                mirq = 1'b1;
                foreach (hist[i]) hist[i] = 1'b1;
            end
        end
        e.p    = mp;
        e.irq  = mirq;
        e.push = {mp[7:6], 1'b1, brk, mp[3:0]};
        sb.push_back(e);
    endtask

    task automatic idle();
        drive(8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    // Assert reset between edges and check it takes effect without a clock.
    task automatic async_reset_pulse();
        @(posedge clk);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check("async_reset_p", bus.p_out, 8'h24);
        check("async_reset_irq", {7'd0, bus.irq_mask}, 8'h01);
    endtask

    // Monitor: every rising edge with an outstanding expectation is compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_p_out", bus.p_out, e.p);
                check("sb_irq_mask", {7'd0, bus.irq_mask}, {7'd0, e.irq});
                check("sb_push_data", bus.push_data, e.push);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        bus.flags_in   = '0;
        bus.flags_ena  = '0;
        bus.flag_op    = '0;
        bus.pull_valid = 1'b0;
        bus.pull_data  = '0;
        bus.int_set_i  = 1'b0;
        bus.push_brk   = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_p_out", bus.p_out, 8'h24);
        check("reset_irq_mask", {7'd0, bus.irq_mask}, 8'h01);
        check("reset_push_data", bus.push_data, 8'h34);

        // ALU mask writes
        drive(8'hFF, 8'hC3, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1);
        @(posedge clk); #2;
        check("alu_mask_1", bus.p_out, 8'hE7);
        drive(8'h00, 8'h02, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1);
        @(posedge clk); #2;
        check("alu_mask_2", bus.p_out, 8'hE5);

        // Flag op beats ALU write; pull beats flag op
        drive(8'h00, 8'h01, 3'd2, 1'b0, 8'h00, 1'b0, 1'b1);
        @(posedge clk); #2;
        check("sec_over_alu", {7'd0, bus.p_out[0]}, 8'h01);
        drive(8'h00, 8'h00, 3'd2, 1'b1, 8'h10, 1'b0, 1'b1);
        @(posedge clk); #2;
        check("pull_over_sec", bus.p_out, 8'h20);

        // Settle I=1, then CLI and watch the delayed mask
        drive(8'h00, 8'h00, 3'd4, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int k = 0; k < int'(D) + 1; k++) idle();
        @(posedge clk); #2;
        check("sei_settled", bus.p_out, 8'h24);
        drive(8'h00, 8'h00, 3'd3, 1'b0, 8'h00, 1'b0, 1'b1);
        @(posedge clk); #2;
        check("cli_p_out", bus.p_out, 8'h20);
        for (int k = 0; k <= int'(D); k++) begin
            check("cli_irq_delay", {7'd0, bus.irq_mask}, (k < int'(D)) ? 8'h01 : 8'h00);
            if (k < int'(D)) begin
                idle();
                @(posedge clk); #2;
            end
        end

        // Interrupt entry beats CLI; push_data before the edge
        drive(8'h00, 8'h00, 3'd3, 1'b0, 8'h00, 1'b1, 1'b0);
        #1;
        check("irq_push_data", bus.push_data, 8'h20);
        @(posedge clk); #2;
        check("int_set_p_out", bus.p_out, 8'h24);
        check("int_set_irq", {7'd0, bus.irq_mask}, 8'h01);

        // Async reset during a pending CLI
        drive(8'h00, 8'h00, 3'd3, 1'b0, 8'h00, 1'b0, 1'b1);
        async_reset_pulse();

        // Randomized phase
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 59) == 0) async_reset_pulse();
            drive(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 7) == 0), 8'($urandom),
                  ($urandom_range(0, 9) == 0), 1'($urandom));
        end

        for (int w = 0; w < 20 && sb.size() > 0; w++) @(posedge clk);
        #3;
        check("scoreboard_drained", 8'(sb.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
